// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// The initiator holds its request until it sees mem_resp.
interface mem_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_resp;

   modport master (
      output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport slave (
      input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      output mem_rdata, mem_resp
   );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder with byte-lane writes and request abort.
// A transaction is latched on acceptance and completes LATENCY edges later with a one-cycle mem_resp.
module mem_responder #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned LATENCY    = 3
) (
   input logic            clk,
   input logic            rst_n,
   mem_responder_if.slave bus
);
   localparam int unsigned Words = 2 ** ADDR_WIDTH;
   localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [15:0]           wdata_q, wdata_d;
   logic [1:0]            be_q, be_d;
   logic                  is_wr_q, is_wr_d;
   logic                  resp_q, resp_d;
   logic [15:0]           rdata_q, rdata_d;

   logic [15:0]           mem [Words];

   logic                  req;
   logic                  complete;
   logic                  commit_wr;
   logic                  cur_wr;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic [15:0]           cur_wdata;
   logic [1:0]            cur_be;
   logic                  unused_addr;

   assign req = bus.mem_read | bus.mem_write;
   // Address bits outside the word index are don't-care (aliasing).
   assign unused_addr = ^bus.mem_address;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      is_wr_d   = is_wr_q;
      complete  = 1'b0;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
      cur_wr    = is_wr_q;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               idx_d   = bus.mem_address[ADDR_WIDTH:1];
               wdata_d = bus.mem_wdata;
               be_d    = bus.mem_byte_enable;
               is_wr_d = bus.mem_write;
               cnt_d   = LatM1;
               if (LATENCY == 1) begin
                  // Completion on the accepting edge uses the live request.
                  state_d   = StResp;
                  complete  = 1'b1;
                  cur_idx   = idx_d;
                  cur_wdata = wdata_d;
                  cur_be    = be_d;
                  cur_wr    = is_wr_d;
               end else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (!req) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d  = StResp;
               complete = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      resp_d    = complete;
      commit_wr = complete & cur_wr & rst_n;
      rdata_d   = (complete && !cur_wr) ? mem[cur_idx] : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 16'h0000;
         be_q    <= 2'b00;
         is_wr_q <= 1'b0;
         resp_q  <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         is_wr_q <= is_wr_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (commit_wr) begin
         if (cur_be[0]) mem[cur_idx][7:0]  <= cur_wdata[7:0];
         if (cur_be[1]) mem[cur_idx][15:8] <= cur_wdata[15:8];
      end
   end

   assign bus.mem_rdata = rdata_q;
   assign bus.mem_resp  = resp_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against an array-based memory model.
// Instance A uses LATENCY=3, instance B uses LATENCY=1.
module tb_mem_responder;
   localparam int unsigned LatA = 3;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   logic [15:0] model_mem [256];
   logic [15:0] model_rdata;

   mem_responder_if bus_a ();
   mem_responder_if bus_b ();

   mem_responder #(.ADDR_WIDTH(8), .LATENCY(LatA)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic idle_a();
      bus_a.mem_read        = 1'b0;
      bus_a.mem_write       = 1'b0;
      bus_a.mem_byte_enable = 2'b00;
      bus_a.mem_address     = 16'h0000;
      bus_a.mem_wdata       = 16'h0000;
   endtask

   task automatic idle_b();
      bus_b.mem_read        = 1'b0;
      bus_b.mem_write       = 1'b0;
      bus_b.mem_byte_enable = 2'b00;
      bus_b.mem_address     = 16'h0000;
      bus_b.mem_wdata       = 16'h0000;
   endtask

   // Full transaction on A; request fields may be scrambled while in flight.
   task automatic txn_a(input logic rd, input logic wr, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] wd, input bit scramble);
      int          edges;
      int          v;
      logic [7:0]  idx;
      bus_a.mem_read        = rd;
      bus_a.mem_write       = wr;
      bus_a.mem_byte_enable = be;
      bus_a.mem_address     = addr;
      bus_a.mem_wdata       = wd;
      @(posedge clk); #1;
      edges = 0;
      while (bus_a.mem_resp !== 1'b1 && edges < 40) begin
         if (scramble) begin
            v = $urandom_range(1, 3);
            bus_a.mem_read        = v[0];
            bus_a.mem_write       = v[1];
            bus_a.mem_address     = 16'($urandom);
            bus_a.mem_wdata       = 16'($urandom);
            bus_a.mem_byte_enable = 2'($urandom);
         end
         @(posedge clk); #1;
         edges++;
      end
      check_eq("latency", edges, LatA);
      idx = addr[8:1];
      if (wr) begin
         if (be[0]) model_mem[idx][7:0]  = wd[7:0];
         if (be[1]) model_mem[idx][15:8] = wd[15:8];
      end else begin
         model_rdata = model_mem[idx];
      end
      check_eq("rdata", bus_a.mem_rdata, model_rdata);
      idle_a();
      @(posedge clk); #1;
      check_eq("resp_width", bus_a.mem_resp, 32'd0);
   endtask

   // Write on A dropped after k edges past acceptance; must never complete.
   task automatic abort_a(input int k, input logic [15:0] addr, input logic [15:0] wd);
      bus_a.mem_write       = 1'b1;
      bus_a.mem_byte_enable = 2'b11;
      bus_a.mem_address     = addr;
      bus_a.mem_wdata       = wd;
      @(posedge clk); #1;
      repeat (k) begin
         @(posedge clk); #1;
      end
      idle_a();
      for (int i = 0; i < int'(LatA) + 2; i++) begin
         @(posedge clk); #1;
         check_eq("abort_resp", bus_a.mem_resp, 32'd0);
      end
      check_eq("abort_rdata", bus_a.mem_rdata, model_rdata);
      txn_a(1'b1, 1'b0, 2'b00, addr, 16'h0000, 1'b0);
   endtask

   initial begin
      int          v;
      logic [15:0] ra;
      n_checks    = 0;
      n_pass      = 0;
      model_rdata = 16'h0000;
      idle_a();
      idle_b();
      rst_n = 1'b0;
      #1;
      check_eq("reset_resp", bus_a.mem_resp, 32'd0);
      check_eq("reset_rdata", bus_a.mem_rdata, 32'd0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Bring every word to a known value.
      for (int i = 0; i < 256; i++) txn_a(1'b0, 1'b1, 2'b11, 16'(i * 2), 16'($urandom), 1'b0);

      txn_a(1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 1'b0);
      txn_a(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0);
      check_eq("beef", bus_a.mem_rdata, 32'h0000BEEF);

      txn_a(1'b0, 1'b1, 2'b11, 16'h0020, 16'h1234, 1'b0);
      txn_a(1'b0, 1'b1, 2'b10, 16'h0020, 16'hAB00, 1'b0);
      txn_a(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 1'b0);
      check_eq("lane_hi", bus_a.mem_rdata, 32'h0000AB34);
      txn_a(1'b0, 1'b1, 2'b11, 16'h0020, 16'h1234, 1'b0);
      txn_a(1'b0, 1'b1, 2'b00, 16'h0020, 16'hAB00, 1'b0);
      txn_a(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 1'b0);
      check_eq("lane_none", bus_a.mem_rdata, 32'h00001234);

      txn_a(1'b0, 1'b1, 2'b11, 16'h0202, 16'h5A5A, 1'b0);
      txn_a(1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, 1'b0);
      check_eq("alias", bus_a.mem_rdata, 32'h00005A5A);

      abort_a(1, 16'h0010, 16'hDEAD);
      check_eq("abort_old", bus_a.mem_rdata, 32'h0000BEEF);

      // Reset pulse in the middle of a write.
      txn_a(1'b0, 1'b1, 2'b11, 16'h0040, 16'h7777, 1'b0);
      txn_a(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b0);
      bus_a.mem_write       = 1'b1;
      bus_a.mem_byte_enable = 2'b11;
      bus_a.mem_address     = 16'h0040;
      bus_a.mem_wdata       = 16'h0F0F;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_async_resp", bus_a.mem_resp, 32'd0);
      check_eq("rst_async_rdata", bus_a.mem_rdata, 32'd0);
      model_rdata = 16'h0000;
      idle_a();
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      txn_a(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b0);
      check_eq("rst_no_commit", bus_a.mem_rdata, 32'h00007777);

      for (int n = 0; n < 300; n++) begin
         ra = 16'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            abort_a($urandom_range(0, LatA - 2), ra, 16'($urandom));
         end else begin
            v = $urandom_range(1, 3);
            txn_a(v[0], v[1], 2'($urandom), ra, 16'($urandom), 1'($urandom));
         end
      end

      // LATENCY=1 instance.
      bus_b.mem_write       = 1'b1;
      bus_b.mem_byte_enable = 2'b11;
      bus_b.mem_address     = 16'h0004;
      bus_b.mem_wdata       = 16'hC3C3;
      @(posedge clk); #1;
      check_eq("b_wr_resp", bus_b.mem_resp, 32'd1);
      idle_b();
      @(posedge clk); #1;
      check_eq("b_wr_drop", bus_b.mem_resp, 32'd0);
      bus_b.mem_read    = 1'b1;
      bus_b.mem_address = 16'h0004;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check_eq("b_held_resp", bus_b.mem_resp, 32'(i % 2 == 0));
         if (i % 2 == 0) check_eq("b_held_rdata", bus_b.mem_rdata, 32'h0000C3C3);
      end
      idle_b();
      @(posedge clk); #1;
      bus_b.mem_read        = 1'b1;
      bus_b.mem_write       = 1'b1;
      bus_b.mem_byte_enable = 2'b11;
      bus_b.mem_address     = 16'h0004;
      bus_b.mem_wdata       = 16'h1111;
      @(posedge clk); #1;
      check_eq("b_both_resp", bus_b.mem_resp, 32'd1);
      check_eq("b_both_rdata", bus_b.mem_rdata, 32'h0000C3C3);
      idle_b();
      @(posedge clk); #1;
      bus_b.mem_read    = 1'b1;
      bus_b.mem_address = 16'h0004;
      @(posedge clk); #1;
      check_eq("b_rd_resp", bus_b.mem_resp, 32'd1);
      check_eq("b_rd_rdata", bus_b.mem_rdata, 32'h00001111);
      idle_b();
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
